// File: rtl/line_fill_engine_pkg.sv
// Shared widths, the line-address type and FSM encoding for the program-cache line fill path.
package kasumi_cache_pkg;
  localparam int unsigned LINE_WIDTH      = 512;
  localparam int unsigned WORD_WIDTH      = 32;
  localparam int unsigned WORDS_PER_LINE  = LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned WORD_CNT_W      = 5;
  localparam int unsigned WORD_IDX_W      = $clog2(WORDS_PER_LINE);
  localparam int unsigned INDEX_WIDTH     = 8;
  localparam int unsigned TAG_WIDTH       = 18;
  localparam int unsigned ADDR_WIDTH      = 32;
  localparam int unsigned MAX_OUTSTANDING = 4;
  localparam int unsigned OUT_W           = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [25:0] line_addr_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DELIVER = 2'd2
  } fill_state_t;
endpackage

// File: rtl/line_fill_engine_if.sv
// Request, backing-memory and fill-port signals of the line fill engine.
interface line_fill_engine_if;
  import kasumi_cache_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  line_addr_t             req_line_addr;
  logic                   mem_rd_valid;
  logic                   mem_rd_ready;
  logic [ADDR_WIDTH-1:0]  mem_rd_addr;
  logic                   mem_rsp_valid;
  logic [WORD_WIDTH-1:0]  mem_rsp_data;
  logic                   fill_valid;
  logic                   fill_ready;
  logic [INDEX_WIDTH-1:0] fill_index;
  logic [TAG_WIDTH-1:0]   fill_tag;
  logic [LINE_WIDTH-1:0]  fill_data;

  // Environment side: requester, backing memory and fill FIFO.
  modport master (
    output req_valid, req_line_addr, mem_rd_ready, mem_rsp_valid, mem_rsp_data, fill_ready,
    input  req_ready, mem_rd_valid, mem_rd_addr, fill_valid, fill_index, fill_tag, fill_data
  );

  modport slave (
    input  req_valid, req_line_addr, mem_rd_ready, mem_rsp_valid, mem_rsp_data, fill_ready,
    output req_ready, mem_rd_valid, mem_rd_addr, fill_valid, fill_index, fill_tag, fill_data
  );
endinterface

// File: rtl/line_fill_engine_assembler.sv
// Collects in-order 32-bit read responses into word slots of a 512-bit line.
module line_assembler
  import kasumi_cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [WORD_WIDTH-1:0] wr_data,
  output logic [LINE_WIDTH-1:0] line_data,
  output logic                  last_word
);
  logic [WORD_CNT_W-1:0] rcv_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      line_data <= '0;
      rcv_cnt   <= '0;
    end else if (clear) begin
      rcv_cnt <= '0;
    end else if (wr_en) begin
      for (int unsigned w = 0; w < WORDS_PER_LINE; w++) begin
        if (rcv_cnt == WORD_CNT_W'(w))
          line_data[w*WORD_WIDTH +: WORD_WIDTH] <= wr_data;
      end
      rcv_cnt <= rcv_cnt + WORD_CNT_W'(1);
    end
  end

  assign last_word = wr_en && (rcv_cnt == WORD_CNT_W'(WORDS_PER_LINE - 1));
endmodule

// File: rtl/line_fill_engine.sv
// Fetches one 64-byte line as 16 word reads (up to 4 in flight) and offers it on the fill port.
module line_fill_engine
  import kasumi_cache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  line_fill_engine_if.slave  bus,
  output logic               busy
);
  fill_state_t           state;
  line_addr_t            line_addr;
  logic [WORD_CNT_W-1:0] issue_cnt;
  logic [OUT_W-1:0]      outstanding;
  logic                  req_fire;
  logic                  rd_fire;
  logic                  rsp_take;
  logic                  fill_fire;
  logic                  last_word;

  assign bus.req_ready    = (state == IDLE) && !reset;
  assign bus.mem_rd_valid = (state == FETCH)
                            && (issue_cnt < WORD_CNT_W'(WORDS_PER_LINE))
                            && (outstanding < OUT_W'(MAX_OUTSTANDING));
  // Word offset is concatenated, not added: a line never carries into the line address.
  assign bus.mem_rd_addr  = {line_addr, issue_cnt[WORD_IDX_W-1:0], 2'b00};
  assign bus.fill_valid   = (state == DELIVER);
  assign bus.fill_index   = line_addr[INDEX_WIDTH-1:0];
  assign bus.fill_tag     = line_addr[INDEX_WIDTH +: TAG_WIDTH];
  assign busy             = (state != IDLE);

  assign req_fire  = bus.req_valid && bus.req_ready;
  assign rd_fire   = bus.mem_rd_valid && bus.mem_rd_ready;
  assign rsp_take  = (state == FETCH) && bus.mem_rsp_valid && (outstanding != '0);
  assign fill_fire = bus.fill_valid && bus.fill_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      line_addr   <= '0;
      issue_cnt   <= '0;
      outstanding <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_fire) begin
            line_addr   <= bus.req_line_addr;
            issue_cnt   <= '0;
            outstanding <= '0;
            state       <= FETCH;
          end
        end
        FETCH: begin
          if (rd_fire)
            issue_cnt <= issue_cnt + WORD_CNT_W'(1);
          if (rd_fire && !rsp_take)
            outstanding <= outstanding + OUT_W'(1);
          else if (!rd_fire && rsp_take)
            outstanding <= outstanding - OUT_W'(1);
          if (last_word)
            state <= DELIVER;
        end
        DELIVER: begin
          if (fill_fire)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  line_assembler u_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (req_fire),
    .wr_en     (rsp_take),
    .wr_data   (bus.mem_rsp_data),
    .line_data (bus.fill_data),
    .last_word (last_word)
  );

  a_outstanding_bound : assert property (@(posedge clk) disable iff (reset)
    outstanding <= OUT_W'(MAX_OUTSTANDING));

  // Responses with nothing in flight are dropped; this records that it happened.
  c_spurious_rsp : cover property (@(posedge clk) disable iff (reset)
    bus.mem_rsp_valid && !rsp_take);
endmodule

// File: tb/tb_line_fill_engine.sv
// Scoreboard bench for line_fill_engine: memory model, request driver and fill monitor.
module tb_line_fill_engine;
  import kasumi_cache_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;

  line_fill_engine_if bus();

  line_fill_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    line_addr_t            a;
    logic [LINE_WIDTH-1:0] data;
    bit                    lat_chk;
    int                    hs_cyc;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;

  exp_t        sb[$];
  logic [31:0] rdq[$];
  pend_t       pend[$];

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  int          lat = 1;
  int          rdy_mode = 0;
  bit          fill_rand = 0;
  int          stall_left = 0;
  bit          plain = 1;
  logic [31:0] salt = 32'hA000_0000;
  bit          spurious = 0;
  int          rsp_cnt = 0;
  logic [31:0] last_rd_addr = '0;
  int          ob_err = 0;
  int          rd_stab_err = 0;
  int          fill_stab_err = 0;
  int          stall_seen = 0;
  int          last_fill_cyc = -1;
  logic [7:0]            last_fill_index;
  logic [17:0]           last_fill_tag;
  logic [LINE_WIDTH-1:0] last_fill_data;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [LINE_WIDTH-1:0] act,
                     input logic [LINE_WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (plain) return salt + {28'd0, a[5:2]};
    return (salt ^ (a * 32'h9E37_79B1)) + {28'd0, a[5:2]};
  endfunction

  function automatic logic [LINE_WIDTH-1:0] model_line(input line_addr_t a);
    logic [LINE_WIDTH-1:0] l;
    l = '0;
    for (int k = 0; k < 16; k++)
      l[32*k +: 32] = mem_word({a, 6'b0} + 32'(4 * k));
    return l;
  endfunction

  // Backing memory: accepts reads, answers in order after lat cycles.
  bit          rd_held = 0;
  logic [31:0] rd_held_addr;
  always @(negedge clk) begin
    if (reset) begin
      pend.delete();
      rd_held = 0;
    end else begin
      if (rd_held && (!bus.mem_rd_valid || bus.mem_rd_addr !== rd_held_addr)) rd_stab_err++;
      rd_held      = bus.mem_rd_valid && !bus.mem_rd_ready;
      rd_held_addr = bus.mem_rd_addr;
      if (bus.mem_rd_valid && bus.mem_rd_ready) begin
        if (pend.size() + (bus.mem_rsp_valid ? 1 : 0) >= MAX_OUTSTANDING) ob_err++;
        if (rdq.size() == 0) begin
          checks++; errs++;
          $display("FAIL rd_unexpected actual=%0h required=no_read", bus.mem_rd_addr);
        end else begin
          chk("rd_addr", bus.mem_rd_addr, rdq.pop_front());
        end
        last_rd_addr = bus.mem_rd_addr;
        pend.push_back('{due: cyc + lat, addr: bus.mem_rd_addr});
      end
    end
  end

  pend_t p;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.mem_rd_ready = 1'b1;
      1:       bus.mem_rd_ready = ~bus.mem_rd_ready;
      default: bus.mem_rd_ready = 1'($urandom_range(0, 1));
    endcase
    bus.mem_rsp_valid = 1'b0;
    if (spurious) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'hDEAD_BEEF;
      spurious = 0;
    end else if (!reset && pend.size() != 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = mem_word(p.addr);
      rsp_cnt++;
    end
  end

  // Fill FIFO sink.
  always @(posedge clk) begin
    #1;
    if (bus.fill_valid && stall_left > 0) begin
      bus.fill_ready = 1'b0;
      stall_left--;
    end else begin
      bus.fill_ready = fill_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Fill monitor: pops the scoreboard on each fill handshake.
  bit   seen = 0;
  bit   held = 0;
  int   first_cyc;
  exp_t e;
  logic [7:0]            h_idx;
  logic [17:0]           h_tag;
  logic [LINE_WIDTH-1:0] h_data;
  always @(negedge clk) begin
    if (reset) begin
      seen = 0;
      held = 0;
    end else if (bus.fill_valid) begin
      if (!seen) begin
        seen = 1;
        first_cyc = cyc;
      end
      if (held && (bus.fill_index !== h_idx || bus.fill_tag !== h_tag || bus.fill_data !== h_data))
        fill_stab_err++;
      if (bus.req_ready) fill_stab_err++;
      if (bus.fill_ready) begin
        last_fill_cyc   = cyc;
        last_fill_index = bus.fill_index;
        last_fill_tag   = bus.fill_tag;
        last_fill_data  = bus.fill_data;
        if (sb.size() == 0) begin
          checks++; errs++;
          $display("FAIL fill_unexpected actual=%0h required=no_fill", bus.fill_index);
        end else begin
          e = sb.pop_front();
          chk("fill_index", bus.fill_index, e.a[7:0]);
          chk("fill_tag", bus.fill_tag, e.a[25:8]);
          chk("fill_data", bus.fill_data, e.data);
          if (e.lat_chk) chk("fill_latency", first_cyc - e.hs_cyc, 18);
        end
        seen = 0;
        held = 0;
      end else begin
        held   = 1;
        stall_seen++;
        h_idx  = bus.fill_index;
        h_tag  = bus.fill_tag;
        h_data = bus.fill_data;
      end
    end else begin
      held = 0;
    end
  end

  task automatic issue_req(input line_addr_t a, input bit lc, output int hs);
    @(posedge clk); #1;
    bus.req_valid     = 1'b1;
    bus.req_line_addr = a;
    hs = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        hs = cyc;
        break;
      end
    end
    if (hs < 0) begin
      checks++; errs++;
      $display("FAIL req_accept_timeout actual=not_accepted required=accepted");
    end else begin
      sb.push_back('{a: a, data: model_line(a), lat_chk: lc, hs_cyc: hs});
      for (int k = 0; k < 16; k++) rdq.push_back({a, 6'b0} + 32'(4 * k));
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || busy) && n < 600);
    if (sb.size() != 0 || busy) begin
      checks++; errs++;
      $display("FAIL %s_timeout actual=busy required=idle", name);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    int hs2;
    int base;
    int n;
    int dead;
    bus.req_valid     = 1'b0;
    bus.req_line_addr = '0;
    bus.mem_rd_ready  = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.fill_ready    = 1'b0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mem_rd_valid", bus.mem_rd_valid, 0);
    chk("rst_mem_rd_addr", bus.mem_rd_addr, 0);
    chk("rst_fill_valid", bus.fill_valid, 0);
    chk("rst_fill_index", bus.fill_index, 0);
    chk("rst_fill_tag", bus.fill_tag, 0);
    chk("rst_fill_data", bus.fill_data, 0);

    // Single fill, plain data pattern, 1-cycle memory.
    plain = 1; salt = 32'hA000_0000; lat = 1; rdy_mode = 0; fill_rand = 0;
    issue_req(26'h0012345, 1'b1, hs);
    wait_idle("single");
    chk("t1_index", last_fill_index, 8'h45);
    chk("t1_tag", last_fill_tag, 18'h00123);
    chk("t1_word0", last_fill_data[31:0], 32'hA000_0000);
    chk("t1_word15", last_fill_data[511:480], 32'hA000_000F);
    chk("t1_last_rd_addr", last_rd_addr, 32'h0048_D17C);

    // Read backpressure with 5-cycle responses.
    plain = 0; salt = $urandom; lat = 5; rdy_mode = 1;
    issue_req(line_addr_t'($urandom), 1'b0, hs);
    wait_idle("rd_backpressure");
    chk("bp_outstanding_bound", ob_err, 0);
    chk("bp_rd_addr_stable", rd_stab_err, 0);

    // Fill backpressure with a second request held pending.
    lat = 1; rdy_mode = 0; fill_rand = 0; stall_seen = 0;
    issue_req(line_addr_t'($urandom), 1'b0, hs);
    stall_left = 10;
    issue_req(line_addr_t'($urandom), 1'b0, hs2);
    chk("req2_accept_cycle", hs2, last_fill_cyc + 1);
    wait_idle("fill_backpressure");
    chk("fill_stall_cycles", stall_seen, 10);
    chk("fill_stable_req_blocked", fill_stab_err, 0);

    // Reset after 7 responses of a fetch.
    salt = $urandom; lat = 1; rdy_mode = 0;
    base = rsp_cnt;
    issue_req(line_addr_t'($urandom), 1'b0, hs);
    n = 0;
    while (rsp_cnt - base < 7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_fetch_responses", (rsp_cnt - base >= 7), 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_req_ready", bus.req_ready, 1);
    chk("abort_mem_rd_valid", bus.mem_rd_valid, 0);
    sb.delete();
    rdq.delete();
    salt = $urandom;
    issue_req(line_addr_t'($urandom), 1'b0, hs);
    wait_idle("after_abort");

    // Highest line address.
    salt = $urandom;
    issue_req(26'h3FF_FFFF, 1'b0, hs);
    wait_idle("wrap");
    chk("wrap_last_rd_addr", last_rd_addr, 32'hFFFF_FFFC);
    chk("wrap_tag", last_fill_tag, 18'h3FFFF);
    chk("wrap_index", last_fill_index, 8'hFF);

    // Spurious response while idle.
    spurious = 1;
    repeat (3) @(negedge clk);
    chk("spurious_busy", busy, 0);
    chk("spurious_req_ready", bus.req_ready, 1);
    chk("spurious_fill_valid", bus.fill_valid, 0);
    salt = $urandom;
    issue_req(line_addr_t'($urandom), 1'b0, hs);
    wait_idle("spurious_next");
    dead = 0;
    for (int k = 0; k < 16; k++)
      if (last_fill_data[32*k +: 32] == 32'hDEAD_BEEF) dead++;
    chk("spurious_no_deadbeef", dead, 0);

    // Randomised traffic.
    for (int i = 0; i < 8; i++) begin
      salt = $urandom;
      lat = $urandom_range(1, 10);
      rdy_mode = $urandom_range(0, 2);
      fill_rand = 1;
      issue_req(line_addr_t'($urandom), 1'b0, hs);
      wait_idle("random");
    end
    chk("final_outstanding_bound", ob_err, 0);
    chk("final_rd_addr_stable", rd_stab_err, 0);
    chk("final_fill_stable", fill_stab_err, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
